// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage feeding the two-phase controller.
// Owns the fetch pointer and issues word reads over a req/ack handshake.
// Returned words are queued with their addresses, and the queue head is
// presented as the IR/PC pair. A redirect (branch/call/return) flushes the
// queue and restarts fetching at the new target.
//
// Configuration macro: IFU_PREFETCH_EN
//   defined   -> queue holds DEPTH entries and fetching runs ahead of use
//   undefined -> single-entry buffer; DEPTH is ignored
//
// Every output is a register. Each next value is computed from the next
// queue/FSM state, so no input reaches an output combinationally.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0004,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir_out,
    output logic [15:0] ir_pc,
    input  logic        ir_take,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

`ifdef IFU_PREFETCH_EN
    localparam int QD = DEPTH;
`else
    // The single-entry build holds one word regardless of DEPTH
    localparam int QD = (DEPTH >= 2) ? 1 : 1;
`endif
    // Pointer width, storage size (power of two) and occupancy-count width
    localparam int PW = (QD > 1) ? $clog2(QD) : 1;
    localparam int QS = 1 << PW;
    localparam int CW = $clog2(QD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    // Advance a queue pointer, wrapping after the last used entry
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(QD - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    state_t        state_r;
    state_t        state_s;
    logic [15:0]   fptr_r;
    logic [15:0]   fptr_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic [CW-1:0] cnt_after_pop_s;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] rd_ptr_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] wr_ptr_s;
    logic [15:0]   pc_q_r    [QS];
    logic [15:0]   instr_q_r [QS];

    logic          pop_s;
    logic          ack_s;
    logic          push_s;
    logic          flush_s;
    logic          bypass_s;

    logic          imem_req_r;
    logic          imem_req_s;
    logic [15:0]   imem_addr_r;
    logic [15:0]   imem_addr_s;
    logic          ir_valid_r;
    logic          ir_valid_s;
    logic [15:0]   ir_out_r;
    logic [15:0]   ir_out_s;
    logic [15:0]   ir_pc_r;
    logic [15:0]   ir_pc_s;

    // Next FSM state, fetch pointer, and push/flush decisions
    always_comb begin
        pop_s           = ir_take & ir_valid_r;
        ack_s           = imem_ack & imem_req_r;
        cnt_after_pop_s = count_r - CW'(pop_s);
        state_s         = state_r;
        fptr_s          = fptr_r;
        push_s          = 1'b0;
        flush_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (redirect) begin
                    flush_s = 1'b1;
                    fptr_s  = redirect_pc;
                    state_s = REQ;
                end else if (cnt_after_pop_s < CW'(QD)) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    // A completing access is simply discarded; an open one
                    // must be allowed to finish at its old address.
                    flush_s = 1'b1;
                    fptr_s  = redirect_pc;
                    if (ack_s) begin
                        state_s = REQ;
                    end else begin
                        state_s = DROP;
                    end
                end else if (ack_s) begin
                    push_s = 1'b1;
                    fptr_s = fptr_r + PC_STEP;
                    if ((cnt_after_pop_s + CW'(1)) < CW'(QD)) begin
                        state_s = REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            DROP: begin
                if (redirect) begin
                    flush_s = 1'b1;
                    fptr_s  = redirect_pc;
                end else begin
                    fptr_s  = fptr_r;
                end
                if (ack_s) begin
                    state_s = REQ;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Next queue bookkeeping and the registered-output values derived from it
    always_comb begin
        if (flush_s) begin
            count_s  = {CW{1'b0}};
            rd_ptr_s = {PW{1'b0}};
            wr_ptr_s = {PW{1'b0}};
        end else begin
            count_s = cnt_after_pop_s + CW'(push_s);
            if (pop_s) begin
                rd_ptr_s = ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            if (push_s) begin
                wr_ptr_s = ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
        end

        // The pushed word becomes the head when nothing else remains queued
        bypass_s   = push_s & (cnt_after_pop_s == {CW{1'b0}});
        ir_valid_s = (count_s != {CW{1'b0}});
        if (!ir_valid_s) begin
            ir_out_s = ir_out_r;
            ir_pc_s  = ir_pc_r;
        end else if (bypass_s) begin
            ir_out_s = imem_rdata;
            ir_pc_s  = fptr_r;
        end else begin
            ir_out_s = instr_q_r[rd_ptr_s];
            ir_pc_s  = pc_q_r[rd_ptr_s];
        end

        // An abandoned access keeps its address until the stale ack arrives
        imem_req_s = (state_s != IDLE);
        if (state_s == DROP) begin
            imem_addr_s = imem_addr_r;
        end else begin
            imem_addr_s = fptr_s;
        end
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Fetch pointer, queue pointers/count and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            fptr_r      <= RESET_PC;
            count_r     <= {CW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
            ir_valid_r  <= 1'b0;
            ir_out_r    <= 16'h0000;
            ir_pc_r     <= 16'h0000;
        end else begin
            fptr_r      <= fptr_s;
            count_r     <= count_s;
            rd_ptr_r    <= rd_ptr_s;
            wr_ptr_r    <= wr_ptr_s;
            imem_req_r  <= imem_req_s;
            imem_addr_r <= imem_addr_s;
            ir_valid_r  <= ir_valid_s;
            ir_out_r    <= ir_out_s;
            ir_pc_r     <= ir_pc_s;
        end
    end

    // Queue storage: the returned word and its address land at the tail
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < QS; i++) begin
                pc_q_r[i]    <= 16'h0000;
                instr_q_r[i] <= 16'h0000;
            end
        end else if (push_s) begin
            pc_q_r[wr_ptr_r]    <= fptr_r;
            instr_q_r[wr_ptr_r] <= imem_rdata;
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign ir_valid  = ir_valid_r;
    assign ir_out    = ir_out_r;
    assign ir_pc     = ir_pc_r;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly upstream of the two-phase controller. Owns the fetch pointer and issues word reads to instruction memory over a req/ack handshake. Buffers returned words, with their addresses, in a small in-order queue, and presents the queue head as the IR/PC pair the controller and datapath consume. A branch, call or return is taken as a redirect, which flushes the queue and restarts fetching at the new target.

## Interface
- RESET_PC, 16'h0000, fetch address loaded on reset
- PC_STEP, 4, fetch-pointer increment per word, matching the datapath's PC+4
- DEPTH, 2, prefetch queue entries (power of two, ≥2); only used with IFU_PREFETCH_EN

Ports:
- clock  in  1  clock; all state changes on posedge
- reset  in  1  reset, synchronous, active-high
- imem_req  out  1  read request to instruction memory
- imem_addr  out  16  read address; stable while imem_req=1 and imem_ack=0
- imem_ack  in  1  memory accepts and completes the request this cycle; sampled only when imem_req=1
- imem_rdata  in  16  instruction word; valid when imem_ack=1
- ir_valid  out  1  queue head holds a valid instruction
- ir_out  out  16  instruction at queue head (controller IR[15:0])
- ir_pc  out  16  address of ir_out
- ir_take  in  1  consumer pops the head (controller ldPC phase); ignored when ir_valid=0
- redirect  in  1  flush the queue and refetch from redirect_pc
- redirect_pc  in  16  new fetch target (PC+4+label, or M[SP] on return)

## Operation
- State: fptr[15:0], queue of {pc, instr} entries, count, and FSM state in {IDLE, REQ, DROP}.
- IDLE: imem_req=0. Move to REQ when the queue is not full and no redirect is present.
- REQ: imem_req=1, imem_addr=fptr.
  - On imem_ack: push {fptr, imem_rdata}, then fptr <= fptr+PC_STEP (mod 2^16).
  - Stay in REQ if space remains after this cycle's push/pop; otherwise go to IDLE.
- Back-to-back: a single cycle may both pop the head and push a new entry. Count is unchanged and order is preserved.
- Redirect has priority over take and over push in the same cycle:
  - The queue is cleared; ir_valid=0 next cycle.
  - fptr <= redirect_pc.
  - From IDLE, or from REQ when imem_ack=1 in the same cycle: go to REQ, with the returned data discarded.
  - From REQ with imem_ack=0: go to DROP. imem_req and imem_addr hold their old values, as the handshake requires.
- DROP: imem_req=1 with the stale address. On imem_ack the data is discarded and the FSM goes to REQ at fptr. A redirect arriving in DROP only overwrites fptr; the FSM stays in DROP.
- ir_take with ir_valid=0 has no effect. Pushes never occur into a full queue.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - ir_valid=0, ir_out=0, ir_pc=0
  - fptr=RESET_PC, count=0, state=IDLE
- Reset mid-handshake drops any outstanding request. The memory must tolerate imem_req being withdrawn.
- imem_req rises one cycle after reset deasserts.
- Latency: imem_ack in cycle N gives ir_valid=1 and ir_out=that word in cycle N+1.
- Throughput: with an empty queue and memory acking in the same cycle as the request, one word per cycle.
- After a redirect in cycle N, the first request goes to redirect_pc in cycle N+1 if nothing is outstanding. If a request is outstanding, it goes out in the cycle after the stale ack.
- All outputs come from registers; there is no combinational path from any input to any output.

## Configuration
- IFU_PREFETCH_EN defined: queue depth is DEPTH, and fetching runs ahead of consumption while space exists.
- IFU_PREFETCH_EN undefined: single-entry buffer and DEPTH is ignored. A new request is issued only after the head has been taken or flushed, so at most one instruction is held. Peak throughput is one word per two cycles with a same-cycle ack.

## Test plan
- Reset, then zero-wait memory, ir_take held at 1: addresses 0x0000, 0x0004, 0x0008… are requested. ir_pc follows the same sequence one cycle after each ack, and ir_out equals the memory contents.
- IFU_PREFETCH_EN, DEPTH=2, ir_take=0: exactly two acks occur, then imem_req=0. After one ir_take, exactly one further request at 0x0008.
- Redirect to 0x0100 while a request to 0x0004 is outstanding, with memory acking 3 cycles later: imem_addr stays at 0x0004 until the ack and that data is never presented. The next request is 0x0100, and the first valid ir_pc is 0x0100.
- Redirect, ir_take and imem_ack in the same cycle with the queue holding 0x0000: the next cycle shows ir_valid=0, and the following request goes to redirect_pc.
- fptr=0xFFFC: after the ack, the next request address is 0x0000 (wrap).
- Assert reset during DROP: the next cycle shows imem_req=0 and ir_valid=0, and fetching restarts at RESET_PC.
